// File: rtl/sme_host.sv
// rtl/sme_host.sv - host-side driver that serialises a buffered string and pattern onto the matching engine
// and reports the engine's result back to the controller.
module sme_host #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_pat,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       start,
  input  logic       keep_str,
  output logic       ready,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       match,
  input  logic [4:0] match_index,
  input  logic       valid,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout
);

  localparam int          SW         = $clog2(STR_MAX);
  localparam int          PW         = $clog2(PAT_MAX);
  localparam logic [5:0]  STR_MAX_L  = 6'(STR_MAX);
  localparam logic [3:0]  PAT_MAX_L  = 4'(PAT_MAX);
  localparam logic [5:0]  PAT_MAX_A  = 6'(PAT_MAX);
  localparam logic [9:0]  TIMEOUT_L  = 10'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SEND_STR, SEND_PAT, WAIT, REPORT} state_t;

  state_t     state, state_next;
  logic [7:0] str_buf [STR_MAX];
  logic [7:0] pat_buf [PAT_MAX];
  logic [5:0] len_s, len_s_c;
  logic [3:0] len_p, len_p_c;
  logic [5:0] idx;
  logic [9:0] cnt;
  logic       str_sent;
  logic       valid_q, match_q;
  logic [4:0] index_q;
  logic [7:0] str_first, pat_first;

  always_comb begin
    len_s_c = str_len;
    if (str_len == 6'd0) len_s_c = 6'd1;
    else if (str_len > STR_MAX_L) len_s_c = STR_MAX_L;
    len_p_c = pat_len;
    if (pat_len == 4'd0) len_p_c = 4'd1;
    else if (pat_len > PAT_MAX_L) len_p_c = PAT_MAX_L;
  end

  // A write to index 0 in the start cycle must reach the first character sent.
  always_comb begin
    str_first = str_buf[0];
    pat_first = pat_buf[0];
    if (wr_en && wr_addr == 5'd0) begin
      if (wr_pat) pat_first = wr_data;
      else        str_first = wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = (keep_str && str_sent) ? SEND_PAT : SEND_STR;
      SEND_STR: if (idx >= len_s) state_next = SEND_PAT;
      SEND_PAT: if (idx >= {2'b00, len_p}) state_next = WAIT;
      WAIT:     if (valid_q || cnt == TIMEOUT_L) state_next = REPORT;
      REPORT:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Engine result is registered first so it is only honoured while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      match_q <= 1'b0;
      index_q <= 5'd0;
    end else begin
      valid_q <= (state == WAIT) && valid;
      if ((state == WAIT) && valid) begin
        match_q <= match;
        index_q <= match_index;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STR_MAX; i++) str_buf[i] <= 8'h20;
      for (int i = 0; i < PAT_MAX; i++) pat_buf[i] <= 8'h00;
      ready     <= 1'b1;
      chardata  <= 8'h00;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      done      <= 1'b0;
      res_match <= 1'b0;
      res_index <= 5'd0;
      timeout   <= 1'b0;
      str_sent  <= 1'b0;
      len_s     <= 6'd1;
      len_p     <= 4'd1;
      idx       <= 6'd0;
      cnt       <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en) begin
            if (!wr_pat && {1'b0, wr_addr} < STR_MAX_L) str_buf[wr_addr[SW-1:0]] <= wr_data;
            if (wr_pat && {1'b0, wr_addr} < PAT_MAX_A)  pat_buf[wr_addr[PW-1:0]] <= wr_data;
          end
          if (start) begin
            ready <= 1'b0;
            len_s <= len_s_c;
            len_p <= len_p_c;
            idx   <= 6'd1;
            if (keep_str && str_sent) begin
              ispattern <= 1'b1;
              chardata  <= pat_first;
            end else begin
              isstring <= 1'b1;
              chardata <= str_first;
            end
          end
        end
        SEND_STR: begin
          if (idx < len_s) begin
            chardata <= str_buf[idx[SW-1:0]];
            idx      <= idx + 6'd1;
          end else begin
            isstring  <= 1'b0;
            ispattern <= 1'b1;
            chardata  <= pat_buf[0];
            idx       <= 6'd1;
            str_sent  <= 1'b1;
          end
        end
        SEND_PAT: begin
          if (idx < {2'b00, len_p}) begin
            chardata <= pat_buf[idx[PW-1:0]];
            idx      <= idx + 6'd1;
          end else begin
            ispattern <= 1'b0;
            chardata  <= 8'h00;
            cnt       <= 10'd0;
          end
        end
        WAIT: begin
          cnt <= cnt + 10'd1;
          if (valid_q) begin
            done      <= 1'b1;
            res_match <= match_q;
            res_index <= index_q;
            timeout   <= 1'b0;
          end else if (cnt == TIMEOUT_L) begin
            done      <= 1'b1;
            res_match <= 1'b0;
            timeout   <= 1'b1;
          end
        end
        REPORT: begin
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sme_host.sv
// tb/tb_sme_host.sv - directed bench for sme_host; the bench plays controller and matching engine.
module tb_sme_host;

  logic       clk = 1'b0;
  logic       reset, wr_en, wr_pat, start, keep_str;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] str_len;
  logic [3:0] pat_len;
  logic       ready, isstring, ispattern, done, res_match, timeout;
  logic [7:0] chardata;
  logic       match, valid;
  logic [4:0] match_index, res_index;

  int checks = 0, errs = 0;
  int n_s = 0, n_p = 0, overlap = 0;
  logic [7:0] s_rx [64];
  logic [7:0] p_rx [64];

  sme_host #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_pat(wr_pat), .wr_addr(wr_addr),
    .wr_data(wr_data), .str_len(str_len), .pat_len(pat_len), .start(start),
    .keep_str(keep_str), .ready(ready), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .match(match), .match_index(match_index), .valid(valid),
    .done(done), .res_match(res_match), .res_index(res_index), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (isstring && n_s < 64) begin s_rx[n_s] = chardata; n_s++; end
    if (ispattern && n_p < 64) begin p_rx[n_p] = chardata; n_p++; end
    if (isstring && ispattern) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic write_byte(input logic p, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_pat = p; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write_str(input logic p, input string s);
    for (int i = 0; i < s.len(); i++) write_byte(p, 5'(i), s[i]);
  endtask

  // td: cycles from WAIT entry to done; dw: done width; ra: cycles to ready
  task automatic run_job(input logic keep, input logic [5:0] sl, input logic [3:0] pl,
                         input logic gv, input logic m, input logic [4:0] mi,
                         input logic we, input logic [7:0] wd,
                         output int td, output int dw, output int ra);
    int c;
    @(negedge clk);
    n_s = 0; n_p = 0;
    str_len = sl; pat_len = pl; keep_str = keep; start = 1'b1;
    wr_en = we; wr_pat = 1'b0; wr_addr = 5'd0; wr_data = wd;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    c = 0;
    while (!ispattern && c < 200) begin @(negedge clk); c++; end
    while (ispattern && c < 200) begin @(negedge clk); c++; end
    if (c >= 200) begin
      checks++; errs++;
      $display("FAIL job_phases: pattern phase never completed within 200 cycles");
    end
    if (gv) begin match = m; match_index = mi; valid = 1'b1; end
    td = -1; dw = 0; ra = -1;
    for (int i = 1; i <= 40 && ra < 0; i++) begin
      @(negedge clk);
      if (i == 1) valid = 1'b0;
      if (done) begin dw++; if (td < 0) td = i; end
      if (ready && td >= 0) ra = i;
    end
  endtask

  task automatic test_reset;
    checks++; if (ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (chardata !== 8'h00) begin errs++; $display("FAIL reset_chardata: got %h want 00", chardata); end
    checks++; if ({isstring, ispattern} !== 2'b00) begin errs++; $display("FAIL reset_strobes: got %b want 00", {isstring, ispattern}); end
    checks++; if ({done, res_match, timeout} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {done, res_match, timeout}); end
    checks++; if (res_index !== 5'd0) begin errs++; $display("FAIL reset_index: got %0d want 0", res_index); end
  endtask

  task automatic test_keep_after_reset;
    int td, dw, ra;
    run_job(1'b1, 6'd4, 4'd2, 1'b1, 1'b0, 5'd3, 1'b0, 8'h00, td, dw, ra);
    checks++; if (n_s !== 4) begin errs++; $display("FAIL kar_nstr: got %0d want 4", n_s); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_rx[i] !== 8'h20) begin errs++; $display("FAIL kar_str[%0d]: got %h want 20", i, s_rx[i]); end
    end
    checks++; if (n_p !== 2) begin errs++; $display("FAIL kar_npat: got %0d want 2", n_p); end
    checks++; if (p_rx[0] !== 8'h00) begin errs++; $display("FAIL kar_pat0: got %h want 00", p_rx[0]); end
    checks++; if (res_match !== 1'b0 || res_index !== 5'd3) begin errs++; $display("FAIL kar_result: got %b/%0d want 0/3", res_match, res_index); end
  endtask

  task automatic test_full_job;
    int td, dw, ra;
    string hs = "hello world";
    string ps = "wor";
    write_str(1'b0, hs);
    write_str(1'b1, ps);
    run_job(1'b0, 6'd11, 4'd3, 1'b1, 1'b1, 5'd6, 1'b0, 8'h00, td, dw, ra);
    checks++; if (n_s !== 11) begin errs++; $display("FAIL full_nstr: got %0d want 11", n_s); end
    for (int i = 0; i < 11; i++) begin
      checks++; if (s_rx[i] !== hs[i]) begin errs++; $display("FAIL full_str[%0d]: got %h want %h", i, s_rx[i], hs[i]); end
    end
    checks++; if (n_p !== 3) begin errs++; $display("FAIL full_npat: got %0d want 3", n_p); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (p_rx[i] !== ps[i]) begin errs++; $display("FAIL full_pat[%0d]: got %h want %h", i, p_rx[i], ps[i]); end
    end
    checks++; if (td !== 2) begin errs++; $display("FAIL full_done_time: got %0d want 2", td); end
    checks++; if (dw !== 1) begin errs++; $display("FAIL full_done_width: got %0d want 1", dw); end
    checks++; if (ra !== 3) begin errs++; $display("FAIL full_ready_time: got %0d want 3", ra); end
    checks++; if ({res_match, res_index, timeout} !== {1'b1, 5'd6, 1'b0}) begin
      errs++; $display("FAIL full_result: got m=%b i=%0d t=%b want 1/6/0", res_match, res_index, timeout); end
    checks++; if ({isstring, ispattern, chardata} !== 10'd0) begin
      errs++; $display("FAIL full_quiescent: got %b%b %h want 0 0 00", isstring, ispattern, chardata); end
  endtask

  task automatic test_timeout;
    int td, dw, ra;
    run_job(1'b1, 6'd11, 4'd3, 1'b0, 1'b0, 5'd0, 1'b0, 8'h00, td, dw, ra);
    checks++; if (n_s !== 0 || n_p !== 3) begin errs++; $display("FAIL to_counts: got %0d/%0d want 0/3", n_s, n_p); end
    checks++; if (td !== 16) begin errs++; $display("FAIL to_done_time: got %0d want 16", td); end
    checks++; if (dw !== 1) begin errs++; $display("FAIL to_done_width: got %0d want 1", dw); end
    checks++; if ({timeout, res_match} !== 2'b10) begin errs++; $display("FAIL to_flags: got t=%b m=%b want 1/0", timeout, res_match); end
    checks++; if (res_index !== 5'd6) begin errs++; $display("FAIL to_index_kept: got %0d want 6", res_index); end
  endtask

  task automatic test_pattern_only;
    int td, dw, ra;
    string ps = "^he";
    write_str(1'b1, ps);
    run_job(1'b1, 6'd11, 4'd3, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00, td, dw, ra);
    checks++; if (n_s !== 0) begin errs++; $display("FAIL po_nstr: got %0d want 0", n_s); end
    checks++; if (n_p !== 3) begin errs++; $display("FAIL po_npat: got %0d want 3", n_p); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (p_rx[i] !== ps[i]) begin errs++; $display("FAIL po_pat[%0d]: got %h want %h", i, p_rx[i], ps[i]); end
    end
    checks++; if ({res_match, res_index, timeout} !== {1'b1, 5'd0, 1'b0}) begin
      errs++; $display("FAIL po_result: got m=%b i=%0d t=%b want 1/0/0", res_match, res_index, timeout); end
  endtask

  task automatic test_clamp_ignored;
    int td, dw, ra;
    logic [7:0] e;
    string hs = "hello world";
    string ps = "^he";
    fork
      run_job(1'b0, 6'd40, 4'd12, 1'b1, 1'b0, 5'd17, 1'b0, 8'h00, td, dw, ra);
      begin
        repeat (4) @(negedge clk);
        start = 1'b1; wr_en = 1'b1; wr_pat = 1'b0; wr_addr = 5'd20; wr_data = 8'h5A;
        @(negedge clk);
        start = 1'b0; wr_pat = 1'b1; wr_addr = 5'd1; wr_data = 8'h51;
        @(negedge clk);
        wr_en = 1'b0;
      end
    join
    checks++; if (n_s !== 32) begin errs++; $display("FAIL cl_nstr: got %0d want 32", n_s); end
    for (int i = 0; i < 32; i++) begin
      e = (i < 11) ? hs[i] : 8'h20;
      checks++; if (s_rx[i] !== e) begin errs++; $display("FAIL cl_str[%0d]: got %h want %h", i, s_rx[i], e); end
    end
    checks++; if (n_p !== 8) begin errs++; $display("FAIL cl_npat: got %0d want 8", n_p); end
    for (int i = 0; i < 8; i++) begin
      e = (i < 3) ? ps[i] : 8'h00;
      checks++; if (p_rx[i] !== e) begin errs++; $display("FAIL cl_pat[%0d]: got %h want %h", i, p_rx[i], e); end
    end
    checks++; if ({res_match, res_index} !== {1'b0, 5'd17}) begin errs++; $display("FAIL cl_result: got %b/%0d want 0/17", res_match, res_index); end
    repeat (3) @(negedge clk);
    checks++; if ({ready, isstring, ispattern} !== 3'b100) begin
      errs++; $display("FAIL cl_no_second_job: got rdy=%b s=%b p=%b want 1 0 0", ready, isstring, ispattern); end
    checks++; if (overlap !== 0) begin errs++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
  endtask

  task automatic test_back_to_back_write_start;
    int td, dw, ra;
    run_job(1'b0, 6'd3, 4'd1, 1'b1, 1'b1, 5'd2, 1'b1, 8'h4A, td, dw, ra);
    checks++; if (n_s !== 3) begin errs++; $display("FAIL bb_nstr: got %0d want 3", n_s); end
    checks++; if (s_rx[0] !== 8'h4A) begin errs++; $display("FAIL bb_str0: got %h want 4a", s_rx[0]); end
    checks++; if (s_rx[1] !== 8'h65 || s_rx[2] !== 8'h6C) begin errs++; $display("FAIL bb_str12: got %h %h want 65 6c", s_rx[1], s_rx[2]); end
    checks++; if (n_p !== 1 || p_rx[0] !== 8'h5E) begin errs++; $display("FAIL bb_pat: got n=%0d %h want 1 5e", n_p, p_rx[0]); end
  endtask

  task automatic test_reset_midjob;
    int td, dw, ra;
    @(negedge clk);
    str_len = 6'd11; pat_len = 4'd3; keep_str = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (isstring !== 1'b1 || chardata !== 8'h6F) begin
      errs++; $display("FAIL rm_fifth_char: got s=%b %h want 1 6f", isstring, chardata); end
    reset = 1'b1;
    #1;
    checks++; if (isstring !== 1'b0) begin errs++; $display("FAIL rm_async_drop: got %b want 0", isstring); end
    checks++; if ({ready, chardata} !== {1'b1, 8'h00}) begin errs++; $display("FAIL rm_outputs: got rdy=%b %h want 1 00", ready, chardata); end
    checks++; if ({res_match, res_index, timeout} !== 7'd0) begin errs++; $display("FAIL rm_results: got %b/%0d/%b want 0/0/0", res_match, res_index, timeout); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errs++; $display("FAIL rm_ready_after: got %b want 1", ready); end
    run_job(1'b1, 6'd4, 4'd1, 1'b1, 1'b1, 5'd9, 1'b0, 8'h00, td, dw, ra);
    checks++; if (n_s !== 4) begin errs++; $display("FAIL rm_full_string: got %0d want 4", n_s); end
    checks++; if (s_rx[0] !== 8'h20 || s_rx[3] !== 8'h20) begin errs++; $display("FAIL rm_buf_reset: got %h %h want 20 20", s_rx[0], s_rx[3]); end
    checks++; if (n_p !== 1 || p_rx[0] !== 8'h00) begin errs++; $display("FAIL rm_pat: got n=%0d %h want 1 00", n_p, p_rx[0]); end
    checks++; if ({res_match, res_index} !== {1'b1, 5'd9}) begin errs++; $display("FAIL rm_result: got %b/%0d want 1/9", res_match, res_index); end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_pat = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
    str_len = 6'd0; pat_len = 4'd0; start = 1'b0; keep_str = 1'b0;
    match = 1'b0; match_index = 5'd0; valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    test_keep_after_reset;
    test_full_job;
    test_timeout;
    test_pattern_only;
    test_clamp_ignored;
    test_back_to_back_write_start;
    test_reset_midjob;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
